// File: rtl/prio_encoder_arb_if.sv
// Request/grant bundle between the request sources (master) and the
// registered priority-encoder arbiter (slave).
interface prio_encoder_arb_if #(
    parameter int N = 8,
    parameter int W = 3
);
    logic [N-1:0] iData;
    logic         iEI;
    logic         iMode;
    logic         iDone;
    logic [W-1:0] oData;
    logic         oValid;
    logic         oEO;

    modport master (
        output iData, iEI, iMode, iDone,
        input  oData, oValid, oEO
    );

    modport slave (
        input  iData, iEI, iMode, iDone,
        output oData, oValid, oEO
    );
endinterface

// File: rtl/prio_encoder_arb.sv
// Registered N-line active-low priority encoder that holds the winning index
// as a grant until released; fixed-priority or round-robin arbitration.
module prio_encoder_arb #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic                 iClk,
    input  logic                 iRst,
    prio_encoder_arb_if.slave    bus
);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    logic [0:0]   r_state;
    logic [W-1:0] r_data;
    logic         r_valid;
    logic         r_eo;
    logic [W-1:0] r_ptr;

    logic [N-1:0] w_req;
    logic [N-1:0] w_hi_mask;
    logic [N-1:0] w_hi_req;
    logic [W-1:0] w_fixed;
    logic [W-1:0] w_lo_all;
    logic [W-1:0] w_lo_hi;
    logic [W-1:0] w_rr;
    logic [W-1:0] w_winner;
    logic [W-1:0] w_ptr_inc;

    assign w_req = ~bus.iData;

    // Lines at or above the pointer get first chance; if none request, the
    // search wraps to the lowest requester overall.
    for (genvar gi = 0; gi < N; gi++) begin : g_mask
        assign w_hi_mask[gi] = (W'(gi) >= r_ptr);
    end
    assign w_hi_req = w_req & w_hi_mask;

    always_comb begin
        w_fixed = '0;
        for (int k = 0; k < N; k++) begin
            if (w_req[k]) w_fixed = W'(k);
        end
    end

    always_comb begin
        w_lo_all = '0;
        w_lo_hi  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_req[k])    w_lo_all = W'(k);
            if (w_hi_req[k]) w_lo_hi  = W'(k);
        end
    end

    assign w_rr      = (|w_hi_req) ? w_lo_hi : w_lo_all;
    assign w_winner  = bus.iMode ? w_rr : w_fixed;
    assign w_ptr_inc = (r_data == W'(N - 1)) ? '0 : r_data + W'(1);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= S_IDLE;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_eo    <= 1'b1;
            r_ptr   <= '0;
        end else begin
            r_eo <= bus.iEI | ~(&bus.iData);
            case (r_state)
                S_IDLE: begin
                    if (!bus.iEI && (|w_req)) begin
                        r_data  <= w_winner;
                        r_valid <= 1'b1;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // Abort wins over iDone and leaves the pointer alone.
                    if (bus.iEI) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (bus.iDone) begin
                        r_ptr   <= w_ptr_inc;
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.oData  = r_data;
    assign bus.oValid = r_valid;
    assign bus.oEO    = r_eo;
endmodule

// File: tb/tb_prio_encoder_arb.sv
// Table-driven, scoreboarded bench for prio_encoder_arb (N=8).
module tb_prio_encoder_arb;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    prio_encoder_arb_if #(.N(8), .W(3)) bus ();

    prio_encoder_arb #(.N(8), .W(3)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus.slave)
    );

    typedef struct {
        logic       rst;
        logic [7:0] data;
        logic       ei;
        logic       mode;
        logic       done;
        logic       ev;
        logic [2:0] ed;
        logic       eeo;
    } vec_t;

    typedef struct {
        logic       v;
        logic [2:0] d;
        logic       eo;
        int         idx;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(logic r, logic [7:0] dt, logic e, logic m, logic dn,
                                logic ev, logic [2:0] ed, logic eeo);
        vec_t t;
        t.rst = r; t.data = dt; t.ei = e; t.mode = m; t.done = dn;
        t.ev = ev; t.ed = ed; t.eeo = eeo;
        return t;
    endfunction

    task automatic check(string name, logic [4:0] act, logic [4:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
            $display("ok   %s {valid,data,eo}=%b", name, act);
        end else begin
            $display("FAIL %s {valid,data,eo} got=%b want=%b", name, act, req);
        end
    endtask

    task automatic drive(vec_t t);
        rst       = t.rst;
        bus.iData = t.data;
        bus.iEI   = t.ei;
        bus.iMode = t.mode;
        bus.iDone = t.done;
    endtask

    initial begin
        exp_t e;
        int   cyc;

        rst = 1'b1; bus.iData = 8'hFF; bus.iEI = 1'b1; bus.iMode = 1'b0; bus.iDone = 1'b0;

        // reset with all lines requesting, then fixed-priority grant of 7
        tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1, 7, 1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0, 7, 1));
        // disabled: no grant, oData holds
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 8'h55, 1, 0, 0, 0, 7, 1));
        tbl.push_back(mk(0, 8'hFF, 0, 0, 0, 0, 7, 0));
        // fixed hold: winner 7 held through iData and iMode changes
        tbl.push_back(mk(0, 8'h55, 0, 0, 0, 1, 7, 1));
        tbl.push_back(mk(0, 8'hFE, 0, 1, 0, 1, 7, 1));
        tbl.push_back(mk(0, 8'hFE, 0, 0, 1, 0, 7, 1));
        tbl.push_back(mk(0, 8'hFE, 0, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 8'hFE, 0, 0, 1, 0, 0, 1));
        // reset clears ptr; iDone in IDLE is ignored
        tbl.push_back(mk(1, 8'h00, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 8'hFF, 0, 1, 1, 0, 0, 0));
        // round-robin sweep 0..7,0
        for (int k = 0; k < 9; k++) begin
            tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 3'(k % 8), 1));
            tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 3'(k % 8), 1));
        end
        // wrap: grant 5 -> ptr 6 -> only line 0 -> grant 0; then line 7 -> ptr 0
        tbl.push_back(mk(0, 8'hDF, 0, 1, 0, 1, 5, 1));
        tbl.push_back(mk(0, 8'hDF, 0, 1, 1, 0, 5, 1));
        tbl.push_back(mk(0, 8'hFE, 0, 1, 0, 1, 0, 1));
        tbl.push_back(mk(0, 8'hFE, 0, 1, 1, 0, 0, 1));
        tbl.push_back(mk(0, 8'h7F, 0, 1, 0, 1, 7, 1));
        tbl.push_back(mk(0, 8'h7F, 0, 1, 1, 0, 7, 1));
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 3'(k), 1));
            tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 3'(k), 1));
        end
        // abort beats iDone, ptr stays 3; then reset mid-grant
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 3, 1));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 0, 3, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 3, 1));
        tbl.push_back(mk(1, 8'h00, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 0, 1));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            e.v = tbl[i].ev; e.d = tbl[i].ed; e.eo = tbl[i].eeo; e.idx = i;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                check($sformatf("vec%0d_noexp", i), {bus.oValid, bus.oData, bus.oEO}, 5'bxxxxx);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("vec%0d", e.idx), {bus.oValid, bus.oData, bus.oEO},
                      {e.v, e.d, e.eo});
            end
        end

        // grant latency: one clock from the sampled request, bounded wait
        @(negedge clk);
        rst = 1'b1; bus.iDone = 1'b0; bus.iEI = 1'b0; bus.iMode = 1'b0; bus.iData = 8'hFF;
        @(negedge clk);
        rst = 1'b0; bus.iData = 8'hEF;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!bus.oValid && cyc < 8);
        check($sformatf("latency_cyc%0d", cyc), {bus.oValid, bus.oData, bus.oEO},
              (cyc == 1) ? 5'b1_100_1 : 5'b0_000_0);

        // grant held for several cycles with no requests and no iDone
        @(negedge clk);
        bus.iData = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        check("hold_idle_lines", {bus.oValid, bus.oData, bus.oEO}, 5'b1_100_0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/prio_encoder_arb.md
Name: prio_encoder_arb

Overview:
- Parametrised, registered successor to the combinational 8-3 priority encoder.
- Encodes N active-low request lines into a binary index and holds the winner as a grant until released.
- Two arbitration modes: fixed priority (highest index wins, 74148-style) and round-robin.
- Sits between request sources and a shared resource that pulses a done signal when service ends.

Parameters:
- N, 8, number of request lines; N >= 2.
- W, 3, index width; must equal ceil(log2(N)).

Ports:
- iClk  in  1  clock, all logic on rising edge.
- iRst  in  1  synchronous reset, active-high.
- iData  in  N  requests, active-low; bit k = 0 means line k requests.
- iEI  in  1  enable input, active-low; 1 means block disabled.
- iMode  in  1  0 = fixed priority, 1 = round-robin.
- iDone  in  1  single-cycle pulse that releases the current grant.
- oData  out  W  granted index, true binary.
- oValid  out  1  1 while a grant is held.
- oEO  out  1  enable output, active-low; 0 when enabled and no request is active.

Behaviour:
- Reset (iRst=1 at an edge): state=IDLE, oData=0, oValid=0, oEO=1, rr pointer ptr=0.
- iRst has priority over every other input, including mid-grant.
- Arbitration uses the active vector req = ~iData.
- State IDLE:
  - If iEI=0 and req != 0: compute winner, register oData=winner, oValid=1, go to GRANT.
  - Grant latency is 1 clock from sampled request to oValid=1.
  - Otherwise stay in IDLE with oValid=0; oData holds its last value.
- Fixed mode (iMode=0): winner = highest set index of req.
- Round-robin mode (iMode=1): search starts at ptr, ascends, and wraps N-1 -> 0; first set bit wins.
- iMode is sampled only at the arbitration edge.
- State GRANT:
  - oData and oValid are held constant regardless of iData or iMode changes.
  - Requester dropping its line does not release the grant; only iDone or abort does.
  - iDone=1 and iEI=0: ptr = (oData+1) mod N, with wrap when oData = N-1. oValid=0, go to IDLE.
  - ptr updates in both modes.
  - iEI=1, with or without iDone: abort. oValid=0, ptr unchanged, go to IDLE. Abort beats iDone.
- There is always at least one IDLE cycle between grants, so oValid drops for at least 1 cycle between consecutive grants.
- iDone while in IDLE is ignored.
- oEO, registered every cycle in every state: oEO = 0 iff iEI=0 and iData is all ones; otherwise 1. It has 1-cycle latency.
- ptr is W bits wide and always < N. For non-power-of-two N, the wrap must skip unused codes.

Test Plan:
- Reset: iRst=1 for 2 cycles with iData=8'b00000000 and iEI=0 -> oValid=0, oData=0, oEO=1 during reset; grant 7 appears 1 cycle after iRst falls (fixed mode).
- Disabled: iEI=1, iData=8'b01010101 for 5 cycles -> oValid stays 0, oEO=1. Then iEI=0, iData=8'hFF -> oEO=0 on the next edge, still no grant.
- Fixed priority hold: iMode=0, iEI=0, iData=8'b01010101 -> oData=7, oValid=1 next edge. Change iData to 8'b11111110 while granted -> oData stays 7. Pulse iDone -> oValid=0 for 1 cycle, then oData=0.
- Round-robin sweep: iMode=1, iData=8'b00000000, ptr=0, iDone pulsed 1 cycle after each grant -> grant sequence 0,1,2,3,4,5,6,7,0.
- Round-robin wrap: after a grant of 5 (ptr=6), iData=8'b11111110 -> grant 0. Next, with iData=8'b01111111, grant 7 -> ptr wraps to 0.
- Abort and reset mid-grant:
  - While granted 3 in RR mode, drive iEI=1 and iDone=1 in the same cycle -> oValid=0 next edge, ptr unchanged (next all-active grant is 3).
  - iRst=1 while granted -> oValid=0, oData=0, ptr=0.
